// File: rtl/game_pkg.sv
// Shared move-code definitions for the input path and game_logic.
// Codes are 2-bit; pulses are one-hot over {up, down, left, right}.
package game_pkg;

  typedef enum logic [1:0] {
    MOVE_UP    = 2'd0,
    MOVE_DOWN  = 2'd1,
    MOVE_LEFT  = 2'd2,
    MOVE_RIGHT = 2'd3
  } move_code_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Same-cycle presses resolve up > down > left > right.
  function automatic move_code_t prio_encode(input dir_t p);
    move_code_t c;
    if (p.up)        c = MOVE_UP;
    else if (p.down) c = MOVE_DOWN;
    else if (p.left) c = MOVE_LEFT;
    else             c = MOVE_RIGHT;
    return c;
  endfunction

  function automatic dir_t decode_move(input move_code_t c);
    dir_t d;
    d = '0;
    case (c)
      MOVE_UP:    d.up    = 1'b1;
      MOVE_DOWN:  d.down  = 1'b1;
      MOVE_LEFT:  d.left  = 1'b1;
      default:    d.right = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// DEPTH x 2-bit FIFO with flush; count/full/empty registered, head read combinationally.
// Push while full is accepted only when a pop happens in the same cycle.
module move_fifo
  import game_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  move_code_t    push_dat,
  input  logic          pop,
  input  logic          flush,
  output move_code_t    head_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  move_code_t    mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & ~flush & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/move_queue.sv
// Edge-detects direction buttons, queues moves, issues one move pulse the cycle after a frame tick.
// Issue holds while logic_busy; presses into a full queue without a same-cycle pop raise overflow.
module move_queue
  import game_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          frame_tick,
  input  logic          logic_busy,
  output logic          move_up,
  output logic          move_down,
  output logic          move_left,
  output logic          move_right,
  output logic [CW-1:0] queue_count,
  output logic          overflow
);

  dir_t       btn;
  dir_t       btn_prev;
  dir_t       press;
  dir_t       move_q;
  logic       any_press;
  logic       pop_req;
  move_code_t push_code;
  move_code_t head_code;
  logic       fifo_full;
  logic       fifo_empty;

  assign btn       = {btn_up, btn_down, btn_left, btn_right};
  assign press     = btn & ~btn_prev;
  assign any_press = enable & (press != '0);
  assign push_code = prio_encode(press);
  assign pop_req   = frame_tick & enable & ~logic_busy & ~fifo_empty;

  // Prev tracks even while disabled so a held button never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev <= '0;
    else        btn_prev <= btn;
  end

  move_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (any_press),
    .push_dat (push_code),
    .pop      (pop_req),
    .flush    (~enable),
    .head_dat (head_code),
    .count    (queue_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_q   <= '0;
      overflow <= 1'b0;
    end else begin
      move_q   <= pop_req ? decode_move(head_code) : dir_t'('0);
      overflow <= any_press & fifo_full & ~pop_req;
    end
  end

  assign move_up    = move_q.up;
  assign move_down  = move_q.down;
  assign move_left  = move_q.left;
  assign move_right = move_q.right;

endmodule
